// File: rtl/command_buffer_control_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | command_buffer_pkg / command_buffer_if : shared line types and bundle  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package command_buffer_pkg;
  typedef enum logic [2:0] {INVALID, READ_CL_NA, READ_CL_S, WRITE_NA, WRITE_MI} psl_command_t;
  typedef enum logic [2:0] {STRICT, ABORT, PAGE, PREF, SPEC} trans_order_t;
  typedef enum logic [1:0] {CMD_INVALID, CMD_READ, CMD_WRITE, CMD_WED} cmd_type_t;
  typedef enum logic [1:0] {STRUCT_INVALID, STRUCT_A, STRUCT_B, STRUCT_C} array_struct_t;

  localparam logic [7:0] INVALID_ID = 8'hFF;
  localparam logic [7:0] WED_ID     = 8'h00;

  typedef struct packed {
    logic [7:0]    cu_id;
    cmd_type_t     cmd_type;
    array_struct_t array_struct;
  } cmd_meta_t;

  typedef struct packed {
    logic         valid;
    psl_command_t command;
    logic [63:0]  address;
    logic [11:0]  size;
    trans_order_t abt;
    cmd_meta_t    cmd;
    logic [7:0]   tag;
  } command_buffer_line_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [1:0] response;
  } response_buffer_line_t;

  typedef struct packed {
    logic empty;
    logic alfull;
    logic full;
  } buffer_status_t;

  localparam command_buffer_line_t RESET_LINE = '{
    valid: 1'b0, command: INVALID, address: 64'd0, size: 12'd0, abt: STRICT,
    cmd: '{cu_id: INVALID_ID, cmd_type: CMD_INVALID, array_struct: STRUCT_INVALID},
    tag: 8'd0};
endpackage

interface command_buffer_if #(parameter int CREDIT_WIDTH = 8);
  import command_buffer_pkg::*;

  logic                  enabled_in;
  logic [CREDIT_WIDTH-1:0] room_in;
  response_buffer_line_t response_in;
  command_buffer_line_t  wed_command_in;
  command_buffer_line_t  cu_command_in;
  buffer_status_t        wed_buffer_status_out;
  buffer_status_t        cu_buffer_status_out;
  command_buffer_line_t  command_out;
  logic [CREDIT_WIDTH-1:0] credits_out;
  logic                  overflow_error_out;

  modport slave (
    input  enabled_in, room_in, response_in, wed_command_in, cu_command_in,
    output wed_buffer_status_out, cu_buffer_status_out, command_out, credits_out,
           overflow_error_out
  );

  modport master (
    output enabled_in, room_in, response_in, wed_command_in, cu_command_in,
    input  wed_buffer_status_out, cu_buffer_status_out, command_out, credits_out,
           overflow_error_out
  );
endinterface
`default_nettype wire

// File: rtl/command_buffer_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | command_buffer_control : two source FIFOs, round-robin, credit-gated  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module command_buffer_control
  import command_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int CREDIT_WIDTH       = 8
) (
  input  wire logic          clock,
  input  wire logic          rstn,
  command_buffer_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALFULL_C = CW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  typedef enum logic [2:0] {
    CMD_RESET, CMD_WAIT_ENABLE, CMD_LOAD_CREDITS, CMD_ISSUE, CMD_PAUSE
  } state_t;

  state_t state, state_next;

  command_buffer_line_t push_line [2];
  command_buffer_line_t head [2];
  buffer_status_t       status_q [2];
  logic [1:0]           nonempty;
  logic [1:0]           drop;
  logic [1:0]           pop;

  logic                    last_grant;   // 0 = WED, 1 = CU
  logic                    can_issue;
  logic                    grant_wed;
  logic                    grant_cu;
  logic [CREDIT_WIDTH-1:0] credits;
  logic [CREDIT_WIDTH-1:0] room_max;
  logic                    overflow;
  command_buffer_line_t    issue_line;
  command_buffer_line_t    command_q;

  assign push_line[0] = bus.wed_command_in;
  assign push_line[1] = bus.cu_command_in;

  // Index 0 is the WED FIFO, index 1 the CU FIFO.
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    command_buffer_line_t mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 push_req;
    logic                 push_ok;
    buffer_status_t       status;

    assign push_req = push_line[s].valid && (state != CMD_RESET);
    // A simultaneous pop frees a slot, so a push into a full FIFO is still legal.
    assign push_ok  = push_req && ((cnt != DEPTH_C) || pop[s]);

    always_comb begin
      cnt_next = cnt;
      case ({push_ok, pop[s]})
        2'b10:   cnt_next = cnt + 1'b1;
        2'b01:   cnt_next = cnt - 1'b1;
        default: cnt_next = cnt;
      endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        status <= '{empty: 1'b1, alfull: 1'b0, full: 1'b0};
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop[s])  rd_ptr <= rd_ptr + 1'b1;
        cnt           <= cnt_next;
        status.empty  <= (cnt_next == '0);
        status.alfull <= (cnt_next >= ALFULL_C);
        status.full   <= (cnt_next == DEPTH_C);
      end
    end

    always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_line[s];
    end

    assign head[s]     = mem[rd_ptr];
    assign nonempty[s] = (cnt != '0);
    assign drop[s]     = push_req && !push_ok;
    assign status_q[s] = status;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= CMD_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CMD_RESET:        state_next = CMD_WAIT_ENABLE;
      CMD_WAIT_ENABLE:  if (bus.enabled_in) state_next = CMD_LOAD_CREDITS;
      CMD_LOAD_CREDITS: state_next = CMD_ISSUE;
      CMD_ISSUE:        if (!bus.enabled_in) state_next = CMD_PAUSE;
      CMD_PAUSE:        if (bus.enabled_in) state_next = CMD_ISSUE;
      default:          state_next = CMD_RESET;
    endcase
  end

  assign can_issue = (state == CMD_ISSUE) && (credits != '0);
  assign grant_wed = can_issue && nonempty[0] && (!nonempty[1] || last_grant);
  assign grant_cu  = can_issue && nonempty[1] && (!nonempty[0] || !last_grant);
  assign pop       = {grant_cu, grant_wed};

  always_comb begin
    issue_line       = grant_wed ? head[0] : head[1];
    issue_line.valid = 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      command_q  <= RESET_LINE;
      last_grant <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (|pop) command_q <= issue_line;
      else      command_q.valid <= 1'b0;
      if (grant_wed)     last_grant <= 1'b0;
      else if (grant_cu) last_grant <= 1'b1;
      if (|drop) overflow <= 1'b1;
    end
  end

  // Returned credits are capped at the room value captured when the AFU enabled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      credits  <= '0;
      room_max <= '0;
    end else if (state == CMD_LOAD_CREDITS) begin
      credits  <= bus.room_in;
      room_max <= bus.room_in;
    end else if ((|pop) && !bus.response_in.valid) begin
      credits <= credits - 1'b1;
    end else if (!(|pop) && bus.response_in.valid && (credits < room_max)) begin
      credits <= credits + 1'b1;
    end
  end

  wire unused_response = ^{bus.response_in.tag, bus.response_in.response};

  assign bus.wed_buffer_status_out = status_q[0];
  assign bus.cu_buffer_status_out  = status_q[1];
  assign bus.command_out           = command_q;
  assign bus.credits_out           = credits;
  assign bus.overflow_error_out    = overflow;

endmodule
`default_nettype wire

// File: tb/tb_command_buffer_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_command_buffer_control : directed bench for command_buffer_control |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_command_buffer_control;
  import command_buffer_pkg::*;

  localparam logic [7:0] CU_ID = 8'h01;

  logic clock;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   nvalid;

  command_buffer_if bus ();

  command_buffer_control dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic command_buffer_line_t mk(input logic [7:0] id, input logic [7:0] tag);
    command_buffer_line_t l;
    l.valid   = 1'b1;
    l.command = READ_CL_NA;
    l.address = {48'h0, tag, 8'h00};
    l.size    = 12'h080;
    l.abt     = STRICT;
    l.cmd     = '{cu_id: id, cmd_type: CMD_READ, array_struct: STRUCT_A};
    l.tag     = tag;
    return l;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wed_command_in = RESET_LINE;
    bus.cu_command_in  = RESET_LINE;
    bus.response_in    = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.enabled_in     = 1'($urandom_range(1));
    bus.room_in        = 8'($urandom_range(255));
    bus.wed_command_in = mk(8'($urandom_range(255)), 8'($urandom_range(255)));
    bus.cu_command_in  = mk(8'($urandom_range(255)), 8'($urandom_range(255)));
    bus.response_in    = '{valid: 1'b1, tag: 8'h3, response: 2'b0};
    tick();
    tick();
    idle_inputs();
    bus.enabled_in = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic start(input logic [7:0] room);
    bus.enabled_in = 1'b1;
    bus.room_in    = room;
    repeat (3) tick();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    bus.enabled_in = 1'b0;
    bus.room_in    = '0;

    // reset values under random inputs
    do_reset();
    rstn = 1'b0;
    bus.wed_command_in = mk(8'h12, 8'h34);
    bus.cu_command_in  = mk(8'h56, 8'h78);
    bus.enabled_in     = 1'b1;
    tick();
    check("rst_cmd",  128'(bus.command_out), 128'(RESET_LINE));
    check("rst_wst",  128'(bus.wed_buffer_status_out), 128'(3'b100));
    check("rst_cst",  128'(bus.cu_buffer_status_out), 128'(3'b100));
    check("rst_cred", 128'(bus.credits_out), 128'(0));
    check("rst_ovf",  128'(bus.overflow_error_out), 128'(0));

    // single WED push latency
    do_reset();
    start(8'd4);
    check("t2_cred0", 128'(bus.credits_out), 128'(4));
    bus.wed_command_in = mk(WED_ID, 8'h05);
    tick();
    idle_inputs();
    check("t2_n1_valid", 128'(bus.command_out.valid), 128'(0));
    check("t2_n1_wst",   128'(bus.wed_buffer_status_out), 128'(3'b000));
    tick();
    check("t2_n2_cmd",  128'(bus.command_out), 128'(mk(WED_ID, 8'h05)));
    check("t2_n2_cred", 128'(bus.credits_out), 128'(3));
    tick();
    check("t2_n3_valid", 128'(bus.command_out.valid), 128'(0));

    // round robin, no gaps
    do_reset();
    start(8'd16);
    for (int k = 0; k < 9; k++) begin
      if (k < 4) begin
        bus.wed_command_in = mk(WED_ID, 8'(k));
        bus.cu_command_in  = mk(CU_ID, 8'(8'h10 + k));
      end else begin
        idle_inputs();
      end
      tick();
      if (k >= 1) begin
        if (((k - 1) % 2) == 0)
          check("t3_rr", 128'(bus.command_out), 128'(mk(WED_ID, 8'((k - 1) / 2))));
        else
          check("t3_rr", 128'(bus.command_out), 128'(mk(CU_ID, 8'(8'h10 + (k - 1) / 2))));
      end
    end
    check("t3_cred", 128'(bus.credits_out), 128'(8));
    tick();
    check("t3_idle", 128'(bus.command_out.valid), 128'(0));

    // credit gating and return
    do_reset();
    start(8'd2);
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 5) bus.cu_command_in = mk(CU_ID, 8'(8'h20 + k));
      else       idle_inputs();
      tick();
      if (bus.command_out.valid) nvalid++;
    end
    check("t4_issued", 128'(nvalid), 128'(2));
    check("t4_cred0",  128'(bus.credits_out), 128'(0));
    bus.response_in = '{valid: 1'b1, tag: 8'h0, response: 2'b0};
    tick();
    bus.response_in = '0;
    check("t4_ret_cred",  128'(bus.credits_out), 128'(1));
    check("t4_ret_valid", 128'(bus.command_out.valid), 128'(0));
    tick();
    check("t4_rel_cmd",  128'(bus.command_out), 128'(mk(CU_ID, 8'h22)));
    check("t4_rel_cred", 128'(bus.credits_out), 128'(0));
    bus.response_in = '{valid: 1'b1, tag: 8'h0, response: 2'b0};
    tick();
    check("t4_r2_cred", 128'(bus.credits_out), 128'(1));
    tick();
    bus.response_in = '0;
    check("t4_same_cmd",  128'(bus.command_out), 128'(mk(CU_ID, 8'h23)));
    check("t4_same_cred", 128'(bus.credits_out), 128'(1));
    tick();
    check("t4_last_cmd",  128'(bus.command_out), 128'(mk(CU_ID, 8'h24)));
    check("t4_last_cred", 128'(bus.credits_out), 128'(0));
    bus.response_in = '{valid: 1'b1, tag: 8'h0, response: 2'b0};
    repeat (3) tick();
    bus.response_in = '0;
    check("t4_sat_cred", 128'(bus.credits_out), 128'(2));
    check("t4_empty",    128'(bus.cu_buffer_status_out), 128'(3'b100));

    // fill, almost-full, full, overflow
    do_reset();
    tick();
    for (int k = 1; k <= 17; k++) begin
      bus.cu_command_in = mk(CU_ID, 8'(8'h40 + k));
      tick();
      idle_inputs();
      if (k == 11) check("t5_alf11",  128'(bus.cu_buffer_status_out), 128'(3'b000));
      if (k == 12) check("t5_alf12",  128'(bus.cu_buffer_status_out), 128'(3'b010));
      if (k == 15) check("t5_full15", 128'(bus.cu_buffer_status_out), 128'(3'b010));
      if (k == 16) begin
        check("t5_full16", 128'(bus.cu_buffer_status_out), 128'(3'b011));
        check("t5_ovf16",  128'(bus.overflow_error_out), 128'(0));
      end
    end
    check("t5_ovf17",  128'(bus.overflow_error_out), 128'(1));
    check("t5_full17", 128'(bus.cu_buffer_status_out), 128'(3'b011));
    check("t5_wst",    128'(bus.wed_buffer_status_out), 128'(3'b100));
    bus.enabled_in = 1'b1;
    bus.room_in    = 8'd20;
    nvalid = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus.command_out.valid) nvalid++;
    end
    check("t5_drain",     128'(nvalid), 128'(16));
    check("t5_drain_cred", 128'(bus.credits_out), 128'(4));
    check("t5_ovf_stick", 128'(bus.overflow_error_out), 128'(1));

    // reset mid-operation
    do_reset();
    start(8'd5);
    bus.enabled_in = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.wed_command_in = mk(WED_ID, 8'(8'h60 + k));
      tick();
    end
    idle_inputs();
    check("t6_pre_cred", 128'(bus.credits_out), 128'(5));
    check("t6_pre_wst",  128'(bus.wed_buffer_status_out), 128'(3'b000));
    check("t6_pre_idle", 128'(bus.command_out.valid), 128'(0));
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_cred", 128'(bus.credits_out), 128'(0));
    check("t6_rst_wst",  128'(bus.wed_buffer_status_out), 128'(3'b100));
    tick();
    rstn = 1'b1;
    bus.enabled_in = 1'b1;
    bus.room_in    = 8'd7;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.command_out.valid) nvalid++;
    end
    check("t6_no_issue", 128'(nvalid), 128'(0));
    check("t6_cred7",    128'(bus.credits_out), 128'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
